npu_psum_accum_rq: RTL and testbench

- Consumer end of the NPU add-tree datapath. Takes the 19-bit dot-product results the add tree produces each cycle and accumulates them over a K-reduction group.
- On the group's last beat, requantizes the sum to 8 bits with rounding and saturation. Results leave through a valid/ready output FIFO.
- Also owns issue-side flow control: in_ready throttles the producer so no in-flight group can overflow the FIFO.

---
 rtl/npu_psum_accum_rq.sv | 207 ++++++++++++++++++++
 tb/tb_npu_psum_accum_rq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/npu_psum_accum_rq.sv
// Partial-sum accumulator and requantizer at the tail of the NPU add tree.
// Aligns issued beats with the add-tree result, accumulates over a reduction
// group with saturation, requantizes the group sum to DWQ bits and queues it
// in a small output FIFO. in_ready reserves FIFO space for in-flight groups.
module npu_psum_accum_rq #(
    parameter int DWOUPUT   = 19,
    parameter int DWACC     = 32,
    parameter int TREE_LAT  = 2,
    parameter int OUT_DEPTH = 4,
    parameter int DWQ       = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic               in_last,
    output logic               in_ready,
    input  logic [DWOUPUT-1:0] add_result,
    input  logic [4:0]         cfg_shift,
    input  logic               cfg_out_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DWQ-1:0]     out_data,
    output logic               out_ovf,
    output logic               acc_busy
);

    localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int SW = $clog2(OUT_DEPTH + TREE_LAT + 1) + 1;

    localparam logic signed [DWACC:0] SMAX = (DWACC+1)'(2**(DWQ-1) - 1);
    localparam logic signed [DWACC:0] SMIN = ~SMAX;
    localparam logic signed [DWACC:0] UMAX = (DWACC+1)'(2**DWQ - 1);

    logic [TREE_LAT-1:0] v_pipe;
    logic [TREE_LAT-1:0] l_pipe;
    logic                v_d;
    logic                l_d;
    logic [SW-1:0]       pend;
    logic                rdy_en;
    logic                take;

    logic [DWACC-1:0]    acc;
    logic                acc_ovf;
    logic                first;
    logic [4:0]          shift_q;
    logic                signed_q;

    logic [DWACC-1:0]    s;
    logic [DWACC:0]      acc_wide;
    logic                add_sat;
    logic [DWACC-1:0]    acc_sum;
    logic [DWACC-1:0]    sum_next;
    logic                ovf_next;
    logic [4:0]          shift_eff;
    logic                signed_eff;
    logic [DWACC:0]      rnd;
    logic signed [DWACC:0] rq_wide;
    logic signed [DWACC:0] rq_sh;
    logic [DWQ-1:0]      q;
    logic                clamp_hit;

    logic [DWQ-1:0]      mem_data [OUT_DEPTH];
    logic                mem_ovf  [OUT_DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [CW-1:0]       fifo_cnt;
    logic                push;
    logic                pop;

    assign v_d = v_pipe[TREE_LAT-1];
    assign l_d = l_pipe[TREE_LAT-1];

    // Count group ends still travelling through the delay pipe.
    always_comb begin
        pend = '0;
        for (int unsigned i = 0; i < TREE_LAT; i++) begin
            pend = pend + SW'(v_pipe[i] & l_pipe[i]);
        end
    end

    // Credit: every in-flight group end plus queued results must fit the FIFO.
    assign in_ready = rdy_en && ((SW'(fifo_cnt) + pend) <= SW'(OUT_DEPTH - 1));
    assign take     = in_valid && in_ready;

    // Ready enable comes up one cycle after reset release; delay pipe shifts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en <= 1'b0;
            v_pipe <= '0;
            l_pipe <= '0;
        end else begin
            rdy_en    <= 1'b1;
            v_pipe[0] <= take;
            l_pipe[0] <= take && in_last;
            for (int unsigned i = 1; i < TREE_LAT; i++) begin
                v_pipe[i] <= v_pipe[i-1];
                l_pipe[i] <= l_pipe[i-1];
            end
        end
    end

    // Saturating accumulate; a group's first beat replaces the sum and config.
    always_comb begin
        s          = {{(DWACC-DWOUPUT){add_result[DWOUPUT-1]}}, add_result};
        acc_wide   = {acc[DWACC-1], acc} + {s[DWACC-1], s};
        add_sat    = acc_wide[DWACC] ^ acc_wide[DWACC-1];
        if (!add_sat) begin
            acc_sum = acc_wide[DWACC-1:0];
        end else if (acc_wide[DWACC]) begin
            acc_sum = {1'b1, {(DWACC-1){1'b0}}};
        end else begin
            acc_sum = {1'b0, {(DWACC-1){1'b1}}};
        end
        sum_next   = first ? s : acc_sum;
        ovf_next   = first ? 1'b0 : (acc_ovf | add_sat);
        shift_eff  = first ? cfg_shift : shift_q;
        signed_eff = first ? cfg_out_signed : signed_q;
    end

    // Round half toward +inf at DWACC+1 bits, arithmetic shift, then clamp.
    always_comb begin
        rnd       = (shift_eff == 5'd0) ? '0 : ((DWACC+1)'(1) << (shift_eff - 5'd1));
        rq_wide   = $signed({sum_next[DWACC-1], sum_next} + rnd);
        rq_sh     = rq_wide >>> shift_eff;
        q         = rq_sh[DWQ-1:0];
        clamp_hit = 1'b0;
        if (signed_eff) begin
            if (rq_sh > SMAX) begin
                q         = SMAX[DWQ-1:0];
                clamp_hit = 1'b1;
            end else if (rq_sh < SMIN) begin
                q         = SMIN[DWQ-1:0];
                clamp_hit = 1'b1;
            end
        end else begin
            if (rq_sh[DWACC]) begin
                q         = '0;
                clamp_hit = 1'b1;
            end else if (rq_sh > UMAX) begin
                q         = '1;
                clamp_hit = 1'b1;
            end
        end
    end

    // Accumulator state: the final beat of a group re-arms for the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            acc_ovf  <= 1'b0;
            first    <= 1'b1;
            shift_q  <= '0;
            signed_q <= 1'b0;
        end else if (v_d) begin
            if (first) begin
                shift_q  <= cfg_shift;
                signed_q <= cfg_out_signed;
            end
            acc <= sum_next;
            if (l_d) begin
                first   <= 1'b1;
                acc_ovf <= 1'b0;
            end else begin
                first   <= 1'b0;
                acc_ovf <= ovf_next;
            end
        end
    end

    assign acc_busy = ~first;

    assign push      = v_d && l_d;
    assign out_valid = (fifo_cnt != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? mem_data[rd_ptr] : '0;
    assign out_ovf   = out_valid ? mem_ovf[rd_ptr] : 1'b0;

    // FIFO storage; entries are only visible through out_valid gating.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= q;
            mem_ovf[wr_ptr]  <= clamp_hit | ovf_next;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    push_when_full_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (fifo_cnt == CW'(OUT_DEPTH))));

endmodule

// File: tb/tb_npu_psum_accum_rq.sv
// Directed bench for npu_psum_accum_rq: table of single/multi-beat groups
// plus hand sequences for latency, back-to-back, backpressure, saturation,
// mid-group config change and asynchronous reset.
module tb_npu_psum_accum_rq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [18:0] add_result;
    logic [4:0]  cfg_shift;
    logic        cfg_out_signed;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_ovf;
    logic        acc_busy;

    logic [18:0] tb_data;
    logic [18:0] dpipe [2];

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        int         n;
        int         d [4];
        logic [4:0] sh;
        logic       sg;
        logic [7:0] q;
        logic       o;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    npu_psum_accum_rq #(
        .DWOUPUT(19), .DWACC(32), .TREE_LAT(2), .OUT_DEPTH(4), .DWQ(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .add_result(add_result),
        .cfg_shift(cfg_shift), .cfg_out_signed(cfg_out_signed),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ovf(out_ovf), .acc_busy(acc_busy)
    );

    always #5 clk = ~clk;

    // Add-tree stand-in: the operand data reappears two cycles after issue.
    always @(posedge clk) begin
        dpipe[0] <= tb_data;
        dpipe[1] <= dpipe[0];
    end
    assign add_result = dpipe[1];

    function automatic vec_t mk(int n, int a, int b, int c, logic [4:0] sh,
                                logic sg, logic [7:0] q, logic o);
        vec_t v;
        v.n = n; v.d[0] = a; v.d[1] = b; v.d[2] = c; v.d[3] = 0;
        v.sh = sh; v.sg = sg; v.q = q; v.o = o;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic issue(input int d, input logic l);
        int w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) chk("issue_ready_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_last  = l;
        tb_data  = 19'(d);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [7:0] q, input logic o);
        int w = 0;
        while (!out_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_data"},  32'(out_data),  32'(q));
        chk({name, "_ovf"},   32'(out_ovf),   32'(o));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepted;

        vecs[0]  = mk(3, 100, 200, -50, 5'd0, 1'b1, 8'h7F, 1'b1);
        vecs[1]  = mk(3, 100, 200, -50, 5'd2, 1'b1, 8'h3F, 1'b0);
        vecs[2]  = mk(1, -3, 0, 0,      5'd1, 1'b1, 8'hFF, 1'b0);
        vecs[3]  = mk(1, -3, 0, 0,      5'd1, 1'b0, 8'h00, 1'b1);
        vecs[4]  = mk(1, -1000, 0, 0,   5'd2, 1'b1, 8'h80, 1'b1);
        vecs[5]  = mk(2, 1000, 20, 0,   5'd2, 1'b0, 8'hFF, 1'b0);
        vecs[6]  = mk(1, 1024, 0, 0,    5'd2, 1'b0, 8'hFF, 1'b1);
        vecs[7]  = mk(1, 5, 0, 0,       5'd1, 1'b1, 8'h03, 1'b0);
        vecs[8]  = mk(1, -5, 0, 0,      5'd1, 1'b1, 8'hFE, 1'b0);
        vecs[9]  = mk(2, 262143, -262144, 0, 5'd0, 1'b1, 8'hFF, 1'b0);
        vecs[10] = mk(1, -128, 0, 0,    5'd0, 1'b1, 8'h80, 1'b0);
        vecs[11] = mk(2, 127, 1, 0,     5'd0, 1'b1, 8'h7F, 1'b1);

        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; tb_data = '0;
        cfg_shift = '0; cfg_out_signed = 1'b1; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_ovf",   32'(out_ovf),   32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_acc_busy",  32'(acc_busy),  32'd0);
        rst_n = 1'b1;
        #1 chk("rel_in_ready_low", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("rel_in_ready_high", 32'(in_ready), 32'd1);

        for (int i = 0; i < NV; i++) begin
            cfg_shift      = vecs[i].sh;
            cfg_out_signed = vecs[i].sg;
            for (int b = 0; b < vecs[i].n; b++)
                issue(vecs[i].d[b], (b == vecs[i].n - 1));
            expect_out($sformatf("vec%0d", i), vecs[i].q, vecs[i].o);
        end

        // Latency: result visible three cycles after the last issue.
        cfg_shift = 5'd0; cfg_out_signed = 1'b1;
        issue(9, 1'b1);
        chk("lat_not_yet0", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_not_yet1", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_ready", 32'(out_valid), 32'd1);
        expect_out("lat", 8'd9, 1'b0);

        // acc_busy during a partially accumulated group.
        issue(1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("busy_mid", 32'(acc_busy), 32'd1);
        issue(2, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("busy_done", 32'(acc_busy), 32'd0);
        expect_out("busy_grp", 8'd3, 1'b0);

        // Back-to-back groups.
        issue(10, 1'b0); issue(20, 1'b1); issue(5, 1'b0); issue(5, 1'b1);
        expect_out("b2b0", 8'd30, 1'b0);
        expect_out("b2b1", 8'd10, 1'b0);

        // Config change mid-group uses the config latched at the first beat.
        cfg_shift = 5'd2;
        issue(100, 1'b0);
        repeat (3) @(negedge clk);
        cfg_shift = 5'd0;
        issue(200, 1'b1);
        expect_out("cfg_hold", 8'd75, 1'b0);

        // Backpressure: six single-beat attempts with the FIFO blocked.
        accepted = 0;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1; in_last = 1'b1;
            tb_data  = 19'(10 * (accepted + 1));
            if (in_ready) accepted++;
            @(negedge clk);
        end
        in_valid = 1'b0; in_last = 1'b0;
        repeat (4) @(negedge clk);
        chk("bp_accepted", 32'(accepted), 32'd4);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        for (int j = 0; j < 4; j++)
            expect_out($sformatf("bp_out%0d", j), 8'(10 * (j + 1)), 1'b0);
        @(negedge clk);
        chk("bp_empty", 32'(out_valid), 32'd0);
        chk("bp_in_ready_back", 32'(in_ready), 32'd1);

        // Accumulator saturation over 2^14 max-positive beats.
        for (int i = 0; i < 16384; i++)
            issue(262143, (i == 16383));
        expect_out("sat", 8'h7F, 1'b1);
        issue(3, 1'b1);
        expect_out("sat_next", 8'd3, 1'b0);

        // Asynchronous reset mid-group with two results queued.
        issue(4, 1'b1);
        issue(6, 1'b1);
        repeat (4) @(negedge clk);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        issue(50, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_acc_busy",  32'(acc_busy),  32'd0);
        chk("arst_in_ready",  32'(in_ready),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(7, 1'b1);
        expect_out("post_rst", 8'd7, 1'b0);
        @(negedge clk);
        chk("post_rst_empty", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
